// File: rtl/uart_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_loader_pkg
//  Description : Shared types and constants for the UART program loader
//                (loader state encoding, error codes, word geometry).
//  Revision    : 1.0  initial release
// ============================================================================
package uart_loader_pkg;

    // Bytes per memory word; also the length-prefix size.
    localparam int WORD_BYTES = 4;

    typedef enum logic [2:0] {
        ST_LEN  = 3'd0,
        ST_DATA = 3'd1,
        ST_SUM  = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } loader_state_t;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_FRAME = 2'd1,
        ERR_LEN   = 2'd2,
        ERR_SUM   = 2'd3
    } loader_err_t;

endpackage : uart_loader_pkg
`default_nettype wire

// File: rtl/uart_loader_packer.sv
`default_nettype none
// ============================================================================
//  Module      : byte_packer
//  Description : Assembles bytes LSB-first into 32-bit words. A 2-bit
//                counter tracks the byte position; o_complete strobes
//                combinationally with the 4th byte, and o_word presents the
//                full word (3 stored bytes plus the current byte) at that time.
//  Revision    : 1.0  initial release
// ============================================================================
module byte_packer
    import uart_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_valid,
    input  logic [7:0]  i_data,
    output logic [31:0] o_word,
    output logic        o_complete
);

    localparam logic [1:0] c_LAST = 2'(WORD_BYTES - 1);

    logic [1:0]  r_cnt;
    logic [23:0] r_shift;

    // Byte position counter and LSB-first shift register; counter wraps 3->0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= 2'd0;
            r_shift <= 24'd0;
        end else if (i_clear) begin
            r_cnt   <= 2'd0;
            r_shift <= 24'd0;
        end else if (i_valid) begin
            r_cnt   <= r_cnt + 2'd1;
            r_shift <= {i_data, r_shift[23:8]};
        end
    end

    // Newest byte lands in the top lane, completing the little-endian word.
    always_comb begin
        o_word     = {i_data, r_shift};
        o_complete = i_valid && (r_cnt == c_LAST);
    end

endmodule : byte_packer
`default_nettype wire

// File: rtl/uart_loader.sv
`default_nettype none
// ============================================================================
//  Module      : uart_loader
//  Description : Parses a length-prefixed little-endian image from the UART
//                byte stream and writes each word to consecutive memory
//                addresses starting at BASE_ADDR. Raises done when complete.
//                Optional feature macro: UART_LOADER_CHECKSUM_EN adds a
//                trailing XOR checksum byte (SUM state, err_code 3).
//  Revision    : 1.0  initial release
// ============================================================================
module uart_loader
    import uart_loader_pkg::*;
#(
    parameter int ADDR_W    = 14,
    parameter int BASE_ADDR = 0,
    parameter int MAX_WORDS = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    input  logic              i_rx_ferr,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [1:0]        o_err_code
);

    localparam logic [32:0]       c_MAX  = 33'(MAX_WORDS);
    localparam logic [ADDR_W-1:0] c_BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   c_ONE  = (ADDR_W + 1)'(1);

    loader_state_t r_state, w_state_nx;
    loader_err_t   r_err_code, w_err_nx;

    // Index and length need one extra bit so a count of 2**ADDR_W fits.
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   r_idx;
    logic [ADDR_W:0]   w_idx_next;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;

    logic        w_byte_ok;
    logic        w_ferr;
    logic        w_pack_valid;
    logic        w_pack_clear;
    logic        w_len_load;
    logic        w_idx_clr;
    logic        w_write;
    logic [31:0] w_word;
    logic        w_complete;

    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_pack_clear),
        .i_valid    (w_pack_valid),
        .i_data     (i_rx_data),
        .o_word     (w_word),
        .o_complete (w_complete)
    );

    assign w_byte_ok  = i_rx_valid && !i_rx_ferr;
    assign w_ferr     = i_rx_valid &&  i_rx_ferr;
    assign w_idx_next = r_idx + c_ONE;

`ifdef UART_LOADER_CHECKSUM_EN
    logic [7:0] r_csum;

    // Running XOR over every accepted length and payload byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_csum <= 8'd0;
        end else if (w_pack_clear) begin
            r_csum <= 8'd0;
        end else if (w_pack_valid) begin
            r_csum <= r_csum ^ i_rx_data;
        end
    end

    localparam loader_state_t c_TAIL = ST_SUM;
`else
    localparam loader_state_t c_TAIL = ST_DONE;
`endif

    // Loader state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_LEN;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state and datapath control decode.
    always_comb begin
        w_state_nx   = r_state;
        w_err_nx     = r_err_code;
        w_pack_valid = 1'b0;
        w_pack_clear = 1'b0;
        w_len_load   = 1'b0;
        w_idx_clr    = 1'b0;
        w_write      = 1'b0;
        case (r_state)
            ST_LEN: begin
                if (w_ferr) begin
                    w_state_nx = ST_ERR;
                    w_err_nx   = ERR_FRAME;
                end else if (w_byte_ok) begin
                    w_pack_valid = 1'b1;
                    if (w_complete) begin
                        if (w_word == 32'd0) begin
                            w_state_nx = c_TAIL;
                        end else if ({1'b0, w_word} > c_MAX) begin
                            w_state_nx = ST_ERR;
                            w_err_nx   = ERR_LEN;
                        end else begin
                            w_state_nx = ST_DATA;
                            w_len_load = 1'b1;
                            w_idx_clr  = 1'b1;
                        end
                    end
                end
            end
            ST_DATA: begin
                if (w_ferr) begin
                    w_state_nx = ST_ERR;
                    w_err_nx   = ERR_FRAME;
                end else if (w_byte_ok) begin
                    w_pack_valid = 1'b1;
                    if (w_complete) begin
                        w_write = 1'b1;
                        if (w_idx_next == r_len) begin
                            w_state_nx = c_TAIL;
                        end
                    end
                end
            end
`ifdef UART_LOADER_CHECKSUM_EN
            ST_SUM: begin
                if (w_ferr) begin
                    w_state_nx = ST_ERR;
                    w_err_nx   = ERR_FRAME;
                end else if (w_byte_ok) begin
                    if (i_rx_data == r_csum) begin
                        w_state_nx = ST_DONE;
                    end else begin
                        w_state_nx = ST_ERR;
                        w_err_nx   = ERR_SUM;
                    end
                end
            end
`endif
            ST_DONE, ST_ERR: begin
                // start wins over a coincident byte, which is dropped.
                if (i_start) begin
                    w_state_nx   = ST_LEN;
                    w_err_nx     = ERR_NONE;
                    w_pack_clear = 1'b1;
                    w_idx_clr    = 1'b1;
                end
            end
            default: begin
                w_state_nx = ST_LEN;
            end
        endcase
    end

    // Length, index, error code and registered memory write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len       <= '0;
            r_idx       <= '0;
            r_err_code  <= ERR_NONE;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 32'd0;
        end else begin
            r_err_code <= w_err_nx;
            r_mem_we   <= w_write;
            if (w_len_load) begin
                r_len <= w_word[ADDR_W:0];
            end
            if (w_idx_clr) begin
                r_idx <= '0;
            end else if (w_write) begin
                r_idx <= w_idx_next;
            end
            if (w_write) begin
                r_mem_addr  <= c_BASE + r_idx[ADDR_W-1:0];
                r_mem_wdata <= w_word;
            end
        end
    end

    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_busy      = (r_state == ST_LEN) || (r_state == ST_DATA) || (r_state == ST_SUM);
    assign o_done      = (r_state == ST_DONE);
    assign o_err       = (r_state == ST_ERR);
    assign o_err_code  = r_err_code;

endmodule : uart_loader
`default_nettype wire

// File: doc/uart_loader.md
# uart_loader

Program-load controller sitting between the UART receiver and instruction/data memory. It consumes the receiver's byte stream (data, one-cycle ready strobe, framing error) and parses a length-prefixed image: a 32-bit little-endian word count, then that many 32-bit little-endian words. Each completed word is written into memory at consecutive addresses. When the image is complete, the block raises `done`, which releases the core from its load phase.

## Interface
- `ADDR_W`, 14: memory word-address width.
- `BASE_ADDR`, 0: word address of the first payload word.
- `MAX_WORDS`, 2**ADDR_W: largest legal word count.
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: one-cycle pulse; re-arms the loader from DONE or ERR.
- `rx_data` in 8: received byte.
- `rx_valid` in 1: one-cycle strobe; `rx_data` is valid this cycle.
- `rx_ferr` in 1: receiver framing-error flag, sampled only when `rx_valid` is high.
- `mem_we` out 1: write strobe, one cycle per word.
- `mem_addr` out ADDR_W: word address.
- `mem_wdata` out 32: assembled word.
- `busy` out 1: high in LEN, DATA and SUM.
- `done` out 1: level, high in DONE.
- `err` out 1: level, high in ERR.
- `err_code` out 2: 0 none, 1 framing, 2 length, 3 checksum.

## Operation
- **States:** LEN, DATA, SUM, DONE, ERR. The reset state is LEN, so the loader is armed immediately after reset.
- **LEN:** collect 4 bytes LSB-first into `len`.
  - On the 4th byte, if `len == 0`, go to SUM when checksum is enabled, else to DONE.
  - If `len > MAX_WORDS`, go to ERR with code 2.
  - Otherwise go to DATA with word index 0.
- **DATA:** collect 4 bytes LSB-first. On the 4th byte:
  - issue a write at `BASE_ADDR + index`;
  - increment the index;
  - when the index reaches `len`, go to SUM or DONE.
- **SUM:** one byte. If it equals the running checksum, go to DONE; else go to ERR with code 3.
- **Framing error:** any `rx_valid` with `rx_ferr` high, in LEN, DATA or SUM, discards the byte and goes to ERR with code 1.
- **DONE / ERR:** further `rx_valid` strobes are ignored. `start` clears the byte counter, index, checksum and `err_code`, then returns to LEN. `start` in any other state is ignored.
- **Byte counter:** 2 bits, wraps 3→0 on word completion. Partial words are never written.
- **Address arithmetic:** `BASE_ADDR + index` is truncated to ADDR_W bits, so addresses wrap modulo 2**ADDR_W.
- **Simultaneous events:** a `start` pulse and `rx_valid` in the same cycle in DONE/ERR both take effect as follows: `start` wins and the byte is dropped.

## Timing
- **Reset values:** `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=1, `done`=0, `err`=0, `err_code`=0.
- **Write latency:** `mem_we`, `mem_addr` and `mem_wdata` are registered. They are valid the cycle after the `rx_valid` carrying the 4th byte. `mem_we` is high for exactly one cycle.
- **Status latency:** `done` and `err` rise the cycle after the terminating byte. For the last word, `done` rises in the same cycle as its `mem_we`.
- **Throughput:** one byte per cycle (back-to-back `rx_valid`) is accepted without loss. No backpressure exists.
- **Reset mid-load:** asynchronous reset mid-load aborts immediately. Memory contents already written are left as is; `done` stays 0 until a full image is received.

## Configuration
- **`UART_LOADER_CHECKSUM_EN` defined:**
  - A trailing SUM byte is required.
  - Checksum = XOR of all length and payload bytes, cleared on reset and `start`.
  - A mismatch gives ERR with code 3.
- **Undefined:**
  - The SUM state and checksum register are absent.
  - The last word (or LEN with `len == 0`) goes straight to DONE.
  - `err_code` 3 is never produced.

## Structure
- **Package `uart_loader_pkg`:**
  - state enum `loader_state_t`;
  - error-code enum `loader_err_t` with `ERR_NONE`, `ERR_FRAME`, `ERR_LEN`, `ERR_SUM`;
  - constant `WORD_BYTES` = 4.
- **Sub-module `byte_packer`:** 2-bit counter plus 32-bit LSB-first shift/assemble, with a word-complete strobe. It is shared by the LEN and DATA phases.

## Test plan
- **Normal load:** checksum off, stream 02 00 00 00, 78 56 34 12, EF BE AD DE → writes 0x12345678 @0 and 0xDEADBEEF @1; `done`=1 with the second write; `err`=0.
- **Zero length:** stream 00 00 00 00 → no `mem_we`; `done` the following cycle.
- **Oversize length:** with ADDR_W=4, stream 11 00 00 00 → ERR, `err_code`=2, no writes.
- **Framing error:** `rx_ferr`=1 on the 6th byte of a 2-word image → ERR, `err_code`=1, no writes. Then `start` followed by a valid image → `done`.
- **Checksum (`UART_LOADER_CHECKSUM_EN`):** stream 01 00 00 00, 04 03 02 01, then SUM = 0x05 → `done`. SUM = 0x06 → `err_code`=3, but the word 0x01020304 @0 is still written.
- **Back-to-back bytes:** `rx_valid` every cycle; assert `rst` after the 3rd payload byte → all outputs return to reset values immediately; no partial write.
